// File: rtl/rs_pkg.sv
// rs_pkg: shared types and helpers for the age-ordered reservation station.
// Payload field widths here are the canonical ones; the rs_age_ordered width
// parameters default to them and must be kept equal.
package rs_pkg;

  localparam int unsigned RS_ROB_W   = 4;
  localparam int unsigned RS_DATA_W  = 32;
  localparam int unsigned RS_ADDR_W  = 32;
  localparam int unsigned RS_OP_W    = 6;
  localparam int unsigned RS_MAX_CDB = 4;

  // ROB tag 0: operand value present, no producer outstanding
  localparam logic [RS_ROB_W-1:0] ROB_NONE = '0;

  typedef struct packed {
    logic                 valid;
    logic [RS_OP_W-1:0]   op;
    logic [RS_DATA_W-1:0] a;
    logic [RS_ROB_W-1:0]  qj;
    logic [RS_DATA_W-1:0] vj;
    logic [RS_ROB_W-1:0]  qk;
    logic [RS_DATA_W-1:0] vk;
    logic [RS_ROB_W-1:0]  dest;
    logic [RS_ADDR_W-1:0] pc;
  } rs_entry_t;

  // Tag of CDB port 'port' from a bus padded to RS_MAX_CDB ports
  function automatic logic [RS_ROB_W-1:0] cdb_tag_slice(
    input logic [RS_MAX_CDB*RS_ROB_W-1:0] bus,
    input int unsigned                    port
  );
    return RS_ROB_W'(bus >> (port * RS_ROB_W));
  endfunction

  // Result of CDB port 'port' from a bus padded to RS_MAX_CDB ports
  function automatic logic [RS_DATA_W-1:0] cdb_data_slice(
    input logic [RS_MAX_CDB*RS_DATA_W-1:0] bus,
    input int unsigned                     port
  );
    return RS_DATA_W'(bus >> (port * RS_DATA_W));
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// rs_age_matrix: DEPTH x DEPTH relative-age matrix for the reservation station.
// age[i][j] = 1 means entry i is older than entry j.
// Ports:
//   clk_in, rst_in : clock, synchronous active-high reset
//   en_in          : global enable, matrix frozen when low
//   clr_in         : clear whole matrix (flush)
//   alloc_in       : one-hot entry being allocated (becomes youngest)
//   free_in        : entries being freed
//   req_in         : request vector
//   oldest_c       : one-hot oldest requester (combinational)
module rs_age_matrix #(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             en_in,
  input  logic             clr_in,
  input  logic [DEPTH-1:0] alloc_in,
  input  logic [DEPTH-1:0] free_in,
  input  logic [DEPTH-1:0] req_in,
  output logic [DEPTH-1:0] oldest_c
);

  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;

  // Allocate: new entry is older than nobody, everyone else is older than it
  always_comb begin
    age_d = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_in[i]) begin
        age_d[i] = '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (j != i) age_d[j][i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (free_in[i]) begin
        age_d[i] = '0;
        for (int j = 0; j < DEPTH; j++) begin
          age_d[j][i] = 1'b0;
        end
      end
    end
    if (clr_in) age_d = '0;
  end

  // Oldest requester: no other requester is older than it
  always_comb begin
    logic blocked;
    oldest_c = '0;
    blocked  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        if (req_in[j] && age_q[j][i]) blocked = 1'b1;
      end
      oldest_c[i] = req_in[i] && !blocked;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      age_q <= '0;
    end else if (en_in) begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/rs_age_ordered.sv
// rs_age_ordered: ALU reservation station with CDB wakeup and strict
// oldest-first issue through a valid/ready output register.
// Ports:
//   clk_in, rst_in   : clock, synchronous active-high reset
//   rdy_in           : global enable (all state frozen when low)
//   flush_in         : misprediction flush, same effect as reset
//   disp_*           : dispatch request and payload
//   rs_rdy_out       : a free entry exists (combinational from valid vector)
//   free_cnt_out     : free entry count (combinational from valid vector)
//   cdb_tag_in/data  : NUM_CDB broadcast ports, port p in slice p
//   iss_*            : registered issue beat, held while not accepted
// Build option: define RS_FAST_WAKEUP_EN to let an entry woken by the CDB this
// cycle be selected in the same cycle, taking the operand straight from the CDB.
module rs_age_ordered
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NUM_CDB = 2,
  parameter int unsigned ROB_W   = RS_ROB_W,
  parameter int unsigned DATA_W  = RS_DATA_W,
  parameter int unsigned ADDR_W  = RS_ADDR_W,
  parameter int unsigned OP_W    = RS_OP_W
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        flush_in,
  input  logic                        disp_en_in,
  input  logic [OP_W-1:0]             disp_op_in,
  input  logic [DATA_W-1:0]           disp_a_in,
  input  logic [ROB_W-1:0]            disp_qj_in,
  input  logic [DATA_W-1:0]           disp_vj_in,
  input  logic [ROB_W-1:0]            disp_qk_in,
  input  logic [DATA_W-1:0]           disp_vk_in,
  input  logic [ROB_W-1:0]            disp_dest_in,
  input  logic [ADDR_W-1:0]           disp_pc_in,
  output logic                        rs_rdy_out,
  output logic [$clog2(DEPTH):0]      free_cnt_out,
  input  logic [NUM_CDB*ROB_W-1:0]    cdb_tag_in,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data_in,
  output logic                        iss_valid_out,
  input  logic                        iss_ready_in,
  output logic [OP_W-1:0]             iss_op_out,
  output logic [DATA_W-1:0]           iss_a_out,
  output logic [DATA_W-1:0]           iss_vj_out,
  output logic [DATA_W-1:0]           iss_vk_out,
  output logic [ROB_W-1:0]            iss_dest_out,
  output logic [ADDR_W-1:0]           iss_pc_out
);

  localparam int unsigned CNT_W      = $clog2(DEPTH) + 1;
  localparam int unsigned TAG_BUS_W  = RS_MAX_CDB * RS_ROB_W;
  localparam int unsigned DATA_BUS_W = RS_MAX_CDB * RS_DATA_W;

  rs_entry_t [DEPTH-1:0] entries_q, entries_d, wake_c;
  rs_entry_t             new_c, sel_c;

  logic [DEPTH-1:0]      valid_c, ready_c, oldest_c, alloc_c, free_c;
  logic [CNT_W-1:0]      free_cnt_c;
  logic                  issue_load_c, disp_acc_c;
  logic [TAG_BUS_W-1:0]  tag_bus_c;
  logic [DATA_BUS_W-1:0] data_bus_c;

  logic                  iss_valid_q, iss_valid_d;
  logic [OP_W-1:0]       iss_op_q, iss_op_d;
  logic [DATA_W-1:0]     iss_a_q, iss_a_d;
  logic [DATA_W-1:0]     iss_vj_q, iss_vj_d;
  logic [DATA_W-1:0]     iss_vk_q, iss_vk_d;
  logic [ROB_W-1:0]      iss_dest_q, iss_dest_d;
  logic [ADDR_W-1:0]     iss_pc_q, iss_pc_d;

  assign tag_bus_c  = TAG_BUS_W'(cdb_tag_in);
  assign data_bus_c = DATA_BUS_W'(cdb_data_in);

  // Occupancy from the registered valid vector
  always_comb begin
    valid_c    = '0;
    free_cnt_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_c[i] = entries_q[i].valid;
      free_cnt_c = free_cnt_c + CNT_W'(!entries_q[i].valid);
    end
  end

  assign rs_rdy_out   = |(~valid_c);
  assign free_cnt_out = free_cnt_c;

  // CDB wakeup of stored entries; lowest port wins on duplicate tags
  always_comb begin
    logic hit_j, hit_k;
    logic [RS_ROB_W-1:0] tag_p;
    wake_c = entries_q;
    hit_j  = 1'b0;
    hit_k  = 1'b0;
    tag_p  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_j = 1'b0;
      hit_k = 1'b0;
      for (int unsigned p = 0; p < NUM_CDB; p++) begin
        tag_p = cdb_tag_slice(tag_bus_c, p);
        if (entries_q[i].valid && !hit_j && entries_q[i].qj != ROB_NONE &&
            tag_p == entries_q[i].qj) begin
          wake_c[i].vj = cdb_data_slice(data_bus_c, p);
          hit_j        = 1'b1;
        end
        if (entries_q[i].valid && !hit_k && entries_q[i].qk != ROB_NONE &&
            tag_p == entries_q[i].qk) begin
          wake_c[i].vk = cdb_data_slice(data_bus_c, p);
          hit_k        = 1'b1;
        end
      end
      if (hit_j) wake_c[i].qj = ROB_NONE;
      if (hit_k) wake_c[i].qk = ROB_NONE;
    end
  end

  // Incoming dispatch payload, capturing any operand broadcast this cycle
  always_comb begin
    logic cap_j, cap_k;
    logic [RS_ROB_W-1:0] tag_p;
    new_c       = '0;
    new_c.valid = 1'b1;
    new_c.op    = RS_OP_W'(disp_op_in);
    new_c.a     = RS_DATA_W'(disp_a_in);
    new_c.qj    = RS_ROB_W'(disp_qj_in);
    new_c.vj    = RS_DATA_W'(disp_vj_in);
    new_c.qk    = RS_ROB_W'(disp_qk_in);
    new_c.vk    = RS_DATA_W'(disp_vk_in);
    new_c.dest  = RS_ROB_W'(disp_dest_in);
    new_c.pc    = RS_ADDR_W'(disp_pc_in);
    cap_j       = 1'b0;
    cap_k       = 1'b0;
    tag_p       = '0;
    for (int unsigned p = 0; p < NUM_CDB; p++) begin
      tag_p = cdb_tag_slice(tag_bus_c, p);
      if (!cap_j && new_c.qj != ROB_NONE && tag_p == new_c.qj) begin
        new_c.vj = cdb_data_slice(data_bus_c, p);
        cap_j    = 1'b1;
      end
      if (!cap_k && new_c.qk != ROB_NONE && tag_p == new_c.qk) begin
        new_c.vk = cdb_data_slice(data_bus_c, p);
        cap_k    = 1'b1;
      end
    end
    if (cap_j) new_c.qj = ROB_NONE;
    if (cap_k) new_c.qk = ROB_NONE;
  end

  // Ready vector feeding the age-ordered select
  always_comb begin
    ready_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_FAST_WAKEUP_EN
      ready_c[i] = wake_c[i].valid && wake_c[i].qj == ROB_NONE &&
                   wake_c[i].qk == ROB_NONE;
`else
      ready_c[i] = entries_q[i].valid && entries_q[i].qj == ROB_NONE &&
                   entries_q[i].qk == ROB_NONE;
`endif
    end
  end

  // Lowest-index free entry receives an accepted dispatch
  always_comb begin
    logic found;
    alloc_c = '0;
    found   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_c[i] && !found) begin
        alloc_c[i] = disp_acc_c;
        found      = 1'b1;
      end
    end
  end

  assign disp_acc_c   = disp_en_in && rs_rdy_out;
  assign issue_load_c = !iss_valid_q || iss_ready_in;
  assign free_c       = issue_load_c ? oldest_c : '0;

  rs_age_matrix #(
    .DEPTH (DEPTH)
  ) u_age (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .en_in    (rdy_in),
    .clr_in   (flush_in),
    .alloc_in (alloc_c),
    .free_in  (free_c),
    .req_in   (ready_c),
    .oldest_c (oldest_c)
  );

  // Payload of the selected entry (post-wakeup view)
  always_comb begin
    sel_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (oldest_c[i]) sel_c = wake_c[i];
    end
  end

  // Next state: wakeup, issue, dispatch; flush overrides everything
  always_comb begin
    entries_d   = wake_c;
    iss_valid_d = iss_valid_q;
    iss_op_d    = iss_op_q;
    iss_a_d     = iss_a_q;
    iss_vj_d    = iss_vj_q;
    iss_vk_d    = iss_vk_q;
    iss_dest_d  = iss_dest_q;
    iss_pc_d    = iss_pc_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (free_c[i])  entries_d[i].valid = 1'b0;
      if (alloc_c[i]) entries_d[i]       = new_c;
    end
    if (issue_load_c) begin
      iss_valid_d = |ready_c;
      if (|ready_c) begin
        iss_op_d   = OP_W'(sel_c.op);
        iss_a_d    = DATA_W'(sel_c.a);
        iss_vj_d   = DATA_W'(sel_c.vj);
        iss_vk_d   = DATA_W'(sel_c.vk);
        iss_dest_d = ROB_W'(sel_c.dest);
        iss_pc_d   = ADDR_W'(sel_c.pc);
      end
    end
    if (flush_in) begin
      entries_d   = '0;
      iss_valid_d = 1'b0;
      iss_op_d    = '0;
      iss_a_d     = '0;
      iss_vj_d    = '0;
      iss_vk_d    = '0;
      iss_dest_d  = '0;
      iss_pc_d    = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      entries_q   <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_a_q     <= '0;
      iss_vj_q    <= '0;
      iss_vk_q    <= '0;
      iss_dest_q  <= '0;
      iss_pc_q    <= '0;
    end else if (rdy_in) begin
      entries_q   <= entries_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_a_q     <= iss_a_d;
      iss_vj_q    <= iss_vj_d;
      iss_vk_q    <= iss_vk_d;
      iss_dest_q  <= iss_dest_d;
      iss_pc_q    <= iss_pc_d;
    end
  end

  assign iss_valid_out = iss_valid_q;
  assign iss_op_out    = iss_op_q;
  assign iss_a_out     = iss_a_q;
  assign iss_vj_out    = iss_vj_q;
  assign iss_vk_out    = iss_vk_q;
  assign iss_dest_out  = iss_dest_q;
  assign iss_pc_out    = iss_pc_q;

endmodule

// File: tb/tb_rs_age_ordered.sv
// tb_rs_age_ordered: directed plus randomized bench for rs_age_ordered,
// compared against a sequence-number based reference model.
module tb_rs_age_ordered;

  localparam int DEPTH   = 8;
  localparam int NUM_CDB = 2;
  localparam int ROB_W   = 4;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int OP_W    = 6;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic                      clk_in = 1'b0;
  logic                      rst_in, rdy_in, flush_in, disp_en_in, iss_ready_in;
  logic [OP_W-1:0]           disp_op_in;
  logic [DATA_W-1:0]         disp_a_in, disp_vj_in, disp_vk_in;
  logic [ROB_W-1:0]          disp_qj_in, disp_qk_in, disp_dest_in;
  logic [ADDR_W-1:0]         disp_pc_in;
  logic                      rs_rdy_out, iss_valid_out;
  logic [CNT_W-1:0]          free_cnt_out;
  logic [NUM_CDB*ROB_W-1:0]  cdb_tag_in;
  logic [NUM_CDB*DATA_W-1:0] cdb_data_in;
  logic [OP_W-1:0]           iss_op_out;
  logic [DATA_W-1:0]         iss_a_out, iss_vj_out, iss_vk_out;
  logic [ROB_W-1:0]          iss_dest_out;
  logic [ADDR_W-1:0]         iss_pc_out;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  rs_age_ordered #(
    .DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .ROB_W(ROB_W),
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_W(OP_W)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .disp_en_in(disp_en_in), .disp_op_in(disp_op_in), .disp_a_in(disp_a_in),
    .disp_qj_in(disp_qj_in), .disp_vj_in(disp_vj_in), .disp_qk_in(disp_qk_in),
    .disp_vk_in(disp_vk_in), .disp_dest_in(disp_dest_in), .disp_pc_in(disp_pc_in),
    .rs_rdy_out(rs_rdy_out), .free_cnt_out(free_cnt_out),
    .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
    .iss_valid_out(iss_valid_out), .iss_ready_in(iss_ready_in),
    .iss_op_out(iss_op_out), .iss_a_out(iss_a_out), .iss_vj_out(iss_vj_out),
    .iss_vk_out(iss_vk_out), .iss_dest_out(iss_dest_out), .iss_pc_out(iss_pc_out)
  );

  // Reference model: entry slots with a dispatch sequence number as age
  bit                m_v    [DEPTH];
  int unsigned       m_seq  [DEPTH];
  logic [OP_W-1:0]   m_op   [DEPTH];
  logic [DATA_W-1:0] m_a    [DEPTH];
  logic [ROB_W-1:0]  m_qj   [DEPTH];
  logic [DATA_W-1:0] m_vj   [DEPTH];
  logic [ROB_W-1:0]  m_qk   [DEPTH];
  logic [DATA_W-1:0] m_vk   [DEPTH];
  logic [ROB_W-1:0]  m_dest [DEPTH];
  logic [ADDR_W-1:0] m_pc   [DEPTH];
  int unsigned       seq_ctr;
  bit                mi_valid;
  logic [OP_W-1:0]   mi_op;
  logic [DATA_W-1:0] mi_a, mi_vj, mi_vk;
  logic [ROB_W-1:0]  mi_dest;
  logic [ADDR_W-1:0] mi_pc;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
    seq_ctr = 0;
    mi_valid = 1'b0; mi_op = '0; mi_a = '0; mi_vj = '0; mi_vk = '0;
    mi_dest = '0; mi_pc = '0;
  endtask

  function automatic int model_free();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (!m_v[i]) n++;
    return n;
  endfunction

  // First CDB port (lowest index) carrying a nonzero tag equal to 'tag'
  function automatic bit cdb_hit(input logic [ROB_W-1:0] tag, output logic [DATA_W-1:0] d);
    logic [ROB_W-1:0] t;
    d = '0;
    if (tag == 0) return 1'b0;
    for (int p = 0; p < NUM_CDB; p++) begin
      t = ROB_W'(cdb_tag_in >> (p * ROB_W));
      if (t == tag) begin
        d = DATA_W'(cdb_data_in >> (p * DATA_W));
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    logic [ROB_W-1:0]  nqj [DEPTH];
    logic [ROB_W-1:0]  nqk [DEPTH];
    logic [DATA_W-1:0] nvj [DEPTH];
    logic [DATA_W-1:0] nvk [DEPTH];
    logic [DATA_W-1:0] d;
    int sel, fidx;
    bit rdy;
    if (rst_in) begin model_reset(); return; end
    if (!rdy_in) return;
    if (flush_in) begin model_reset(); return; end
    for (int i = 0; i < DEPTH; i++) begin
      nqj[i] = m_qj[i]; nqk[i] = m_qk[i]; nvj[i] = m_vj[i]; nvk[i] = m_vk[i];
      if (m_v[i] && cdb_hit(m_qj[i], d)) begin nqj[i] = 0; nvj[i] = d; end
      if (m_v[i] && cdb_hit(m_qk[i], d)) begin nqk[i] = 0; nvk[i] = d; end
    end
    sel = -1;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_FAST_WAKEUP_EN
      rdy = m_v[i] && nqj[i] == 0 && nqk[i] == 0;
`else
      rdy = m_v[i] && m_qj[i] == 0 && m_qk[i] == 0;
`endif
      if (rdy && (sel < 0 || m_seq[i] < m_seq[sel])) sel = i;
    end
    fidx = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) fidx = i;
    for (int i = 0; i < DEPTH; i++) begin
      m_qj[i] = nqj[i]; m_qk[i] = nqk[i]; m_vj[i] = nvj[i]; m_vk[i] = nvk[i];
    end
    if (!mi_valid || iss_ready_in) begin
      mi_valid = (sel >= 0);
      if (sel >= 0) begin
        mi_op = m_op[sel]; mi_a = m_a[sel]; mi_vj = m_vj[sel]; mi_vk = m_vk[sel];
        mi_dest = m_dest[sel]; mi_pc = m_pc[sel];
        m_v[sel] = 1'b0;
      end
    end
    if (disp_en_in && fidx >= 0) begin
      m_v[fidx] = 1'b1; m_seq[fidx] = seq_ctr; seq_ctr++;
      m_op[fidx] = disp_op_in; m_a[fidx] = disp_a_in; m_dest[fidx] = disp_dest_in;
      m_pc[fidx] = disp_pc_in;
      m_qj[fidx] = disp_qj_in; m_vj[fidx] = disp_vj_in;
      m_qk[fidx] = disp_qk_in; m_vk[fidx] = disp_vk_in;
      if (cdb_hit(disp_qj_in, d)) begin m_qj[fidx] = 0; m_vj[fidx] = d; end
      if (cdb_hit(disp_qk_in, d)) begin m_qk[fidx] = 0; m_vk[fidx] = d; end
    end
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("iss_valid", 256'(iss_valid_out), 256'(mi_valid));
    chk("free_cnt", 256'(free_cnt_out), 256'(model_free()));
    chk("rs_rdy", 256'(rs_rdy_out), 256'(model_free() > 0));
    if (mi_valid)
      chk("iss_payload",
          256'({iss_op_out, iss_a_out, iss_vj_out, iss_vk_out, iss_dest_out, iss_pc_out}),
          256'({mi_op, mi_a, mi_vj, mi_vk, mi_dest, mi_pc}));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
    check_model();
  endtask

  task automatic disp(input logic [ROB_W-1:0] qj, input logic [ROB_W-1:0] qk,
                      input logic [ROB_W-1:0] dest);
    disp_en_in = 1'b1; disp_qj_in = qj; disp_qk_in = qk; disp_dest_in = dest;
    disp_op_in = OP_W'(dest + 1); disp_a_in = 32'h1000 + 32'(dest);
    disp_vj_in = 32'hA000 + 32'(dest); disp_vk_in = 32'hB000 + 32'(dest);
    disp_pc_in = 32'h400 + 32'(dest) * 4;
  endtask

  task automatic idle();
    disp_en_in = 1'b0; flush_in = 1'b0; cdb_tag_in = '0; cdb_data_in = '0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; iss_ready_in = 1'b1;
    disp_qj_in = '0; disp_qk_in = '0; disp_dest_in = '0; disp_op_in = '0;
    disp_a_in = '0; disp_vj_in = '0; disp_vk_in = '0; disp_pc_in = '0;
    idle();
    model_reset();
    @(negedge clk_in);
    tick(); tick();
    chk("reset_payload",
        256'({iss_op_out, iss_a_out, iss_vj_out, iss_vk_out, iss_dest_out, iss_pc_out}), 256'(0));
    chk("reset_free", 256'(free_cnt_out), 256'(8));
    rst_in = 1'b0;

    // Three ready entries issue in order on consecutive cycles
    for (int n = 1; n <= 3; n++) begin disp(0, 0, ROB_W'(n)); tick(); end
    idle(); tick(); tick(); tick();
    chk("t1_free_back", 256'(free_cnt_out), 256'(8));

    // A waits on tag 5, B ready; B issues first, A gets 0xDEAD
    disp(5, 0, 4'd10); tick();
    disp(0, 0, 4'd11); tick();
    idle(); cdb_tag_in = {4'd5, 4'd0}; cdb_data_in = {32'hDEAD, 32'h0}; tick();
`ifndef RS_FAST_WAKEUP_EN
    chk("t2_b_first", 256'(iss_dest_out), 256'(11));
`endif
    idle(); tick();
`ifndef RS_FAST_WAKEUP_EN
    chk("t2_a_vj", 256'({iss_dest_out, iss_vj_out}), 256'({4'd10, 32'hDEAD}));
`endif
    tick(); tick();

    // Fill all entries, 9th dispatch ignored, one issue frees one slot
    for (int n = 0; n < 8; n++) begin disp(7, 0, ROB_W'(n + 1)); tick(); end
    chk("t3_full_rdy", 256'(rs_rdy_out), 256'(0));
    chk("t3_full_cnt", 256'(free_cnt_out), 256'(0));
    disp(0, 0, 4'd15); tick();
    chk("t3_ninth_ignored", 256'(free_cnt_out), 256'(0));
    idle(); iss_ready_in = 1'b0; cdb_tag_in = {4'd0, 4'd7}; cdb_data_in = {32'h0, 32'h77}; tick();
    idle(); tick();
    chk("t3_one_free", 256'(free_cnt_out), 256'(1));
    tick(); tick();
    iss_ready_in = 1'b1;
    for (int n = 0; n < 10; n++) tick();
    chk("t3_drained", 256'(free_cnt_out), 256'(8));

    // Back-pressure: two ready entries, output held for four cycles
    iss_ready_in = 1'b0;
    disp(0, 0, 4'd1); tick();
    disp(0, 0, 4'd2); tick();
    idle();
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("t4_held_oldest", 256'({iss_valid_out, iss_dest_out}), 256'({1'b1, 4'd1}));
    end
    iss_ready_in = 1'b1; tick();
    chk("t4_second", 256'(iss_dest_out), 256'(2));
    tick(); tick();

    // Dispatch captures a same-cycle broadcast
    disp(0, 3, 4'd6); cdb_tag_in = {4'd0, 4'd3}; cdb_data_in = {32'h0, 32'h42}; tick();
    idle(); tick();
    chk("t5_vk_capture", 256'({iss_valid_out, iss_vk_out}), 256'({1'b1, 32'h42}));
    tick();

    // rdy_in low freezes everything
    rdy_in = 1'b0; disp(0, 0, 4'd9); tick(); tick();
    chk("frozen_free", 256'(free_cnt_out), 256'(8));
    rdy_in = 1'b1; idle(); tick(); tick();

    // Flush together with dispatch
    for (int n = 0; n < 4; n++) begin disp(9, 0, ROB_W'(n + 1)); tick(); end
    disp(0, 0, 4'd12); flush_in = 1'b1; tick();
    chk("t6_flush", 256'({iss_valid_out, free_cnt_out}), 256'({1'b0, 4'd8}));
    idle(); tick();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rdy_in       = ($urandom_range(0, 9) != 0);
      flush_in     = ($urandom_range(0, 39) == 0);
      iss_ready_in = ($urandom_range(0, 9) < 7);
      disp_en_in   = ($urandom_range(0, 1) == 1);
      disp_qj_in   = ($urandom_range(0, 2) == 0) ? ROB_W'($urandom_range(1, 15)) : '0;
      disp_qk_in   = ($urandom_range(0, 2) == 0) ? ROB_W'($urandom_range(1, 15)) : '0;
      disp_dest_in = ROB_W'($urandom);
      disp_op_in   = OP_W'($urandom);
      disp_a_in    = $urandom; disp_vj_in = $urandom; disp_vk_in = $urandom;
      disp_pc_in   = $urandom;
      for (int p = 0; p < NUM_CDB; p++) begin
        cdb_tag_in[p*ROB_W +: ROB_W] = ($urandom_range(0, 1) == 0) ? '0 : ROB_W'($urandom_range(1, 15));
        cdb_data_in[p*DATA_W +: DATA_W] = $urandom;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
